// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared constants for the 5-stage RISC-V core pipeline.
//   XLEN / RA_W        : datapath and register-address widths
//   FWD_RF/FWD_W/FWD_M : forward-select encodings used by the execute stage
//   RES_ALU/LOAD/PC4   : result-source encodings
//   FWD_EN             : 1 when built with `define EX_FORWARD_EN, else 0.
//                        With forwarding off, RAW hazards against E and M are
//                        resolved by stalling instead.
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

`ifdef EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundle between decode / later stages and the decode-to-execute stage.
//   master : whoever drives decode operands, M/W feedback and stall/flush
//   slave  : the id_ex_stage itself
// Decode side  : *_d operands and control, stall_e, flush_e
// Feedback     : rd_m, reg_write_m, alu_result_m, rd_w, reg_write_w, result_w
// Execute side : src_a_e, src_b_e, write_data_e, registered copies, forward
//                selects, load_use_stall, plus rs1_e/rs2_e so hazard checkers
//                can observe the registered source addresses.
// Handshake: there is no valid/ready pair. Each rising edge the stage either
// accepts decode (stall_e=0), holds (stall_e=1) or takes a bubble (flush_e=1,
// which wins over stall_e); load_use_stall is the backpressure to decode.
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
);
  logic            stall_e;
  logic            flush_e;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  logic [XLEN-1:0] imm_ext_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4_d;
  logic [RA_W-1:0] rs1_d;
  logic [RA_W-1:0] rs2_d;
  logic [RA_W-1:0] rd_d;
  logic [2:0]      alu_control_d;
  logic            alu_src_d;
  logic            reg_write_d;
  logic            mem_write_d;
  logic            branch_d;
  logic            jump_d;
  logic [1:0]      result_src_d;

  logic [RA_W-1:0] rd_m;
  logic            reg_write_m;
  logic [XLEN-1:0] alu_result_m;
  logic [RA_W-1:0] rd_w;
  logic            reg_write_w;
  logic [XLEN-1:0] result_w;

  logic [XLEN-1:0] src_a_e;
  logic [XLEN-1:0] src_b_e;
  logic [2:0]      alu_control_e;
  logic [XLEN-1:0] write_data_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] imm_ext_e;
  logic [XLEN-1:0] pc_plus4_e;
  logic [RA_W-1:0] rd_e;
  logic [RA_W-1:0] rs1_e;
  logic [RA_W-1:0] rs2_e;
  logic            reg_write_e;
  logic            mem_write_e;
  logic            branch_e;
  logic            jump_e;
  logic [1:0]      result_src_e;
  logic [1:0]      forward_a_e;
  logic [1:0]      forward_b_e;
  logic            load_use_stall;

  modport master (
    output stall_e, flush_e, rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d,
           rs1_d, rs2_d, rd_d, alu_control_d, alu_src_d, reg_write_d,
           mem_write_d, branch_d, jump_d, result_src_d,
           rd_m, reg_write_m, alu_result_m, rd_w, reg_write_w, result_w,
    input  src_a_e, src_b_e, alu_control_e, write_data_e, pc_e, imm_ext_e,
           pc_plus4_e, rd_e, rs1_e, rs2_e, reg_write_e, mem_write_e,
           branch_e, jump_e, result_src_e, forward_a_e, forward_b_e,
           load_use_stall
  );

  modport slave (
    input  stall_e, flush_e, rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d,
           rs1_d, rs2_d, rd_d, alu_control_d, alu_src_d, reg_write_d,
           mem_write_d, branch_d, jump_d, result_src_d,
           rd_m, reg_write_m, alu_result_m, rd_w, reg_write_w, result_w,
    output src_a_e, src_b_e, alu_control_e, write_data_e, pc_e, imm_ext_e,
           pc_plus4_e, rd_e, rs1_e, rs2_e, reg_write_e, mem_write_e,
           branch_e, jump_e, result_src_e, forward_a_e, forward_b_e,
           load_use_stall
  );
endinterface

// File: rtl/id_ex_stage_forwarding_unit.sv
// -----------------------------------------------------------------------------
// forwarding_unit
// Purely combinational forward-select generation for the execute stage.
//   rs1_e_i, rs2_e_i         : registered source addresses in E
//   rd_m_i, reg_write_m_i    : M-stage destination and write enable
//   rd_w_i, reg_write_w_i    : W-stage destination and write enable
//   forward_a_e_o/b_e_o      : FWD_M (newest value) over FWD_W over FWD_RF
// x0 is never forwarded: it reads as zero regardless of pending writes.
// -----------------------------------------------------------------------------
module forwarding_unit
  import core_pkg::*;
#(
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic [RA_W-1:0] rs1_e_i,
  input  logic [RA_W-1:0] rs2_e_i,
  input  logic [RA_W-1:0] rd_m_i,
  input  logic            reg_write_m_i,
  input  logic [RA_W-1:0] rd_w_i,
  input  logic            reg_write_w_i,
  output logic [1:0]      forward_a_e_o,
  output logic [1:0]      forward_b_e_o
);

  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] rs,
    input logic [RA_W-1:0] rd_m,
    input logic            we_m,
    input logic [RA_W-1:0] rd_w,
    input logic            we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (we_m && (rd_m == rs)) begin
        sel = FWD_M;
      end else if (we_w && (rd_w == rs)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  assign forward_a_e_o = fwd_sel(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
  assign forward_b_e_o = fwd_sel(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register with hazard resolution, feeding the ALU.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   ex_if    : id_ex_stage_if.slave (decode inputs, M/W feedback, E outputs)
// The E register captures every decode field. rst and flush_e load an all-zero
// bubble (flush wins over stall_e); stall_e holds the register.
// Operand A, store data and operand B are built from the registered operands,
// optionally replaced by M/W results when a forward select hits.
// Build option: `define EX_FORWARD_EN enables forwarding. Without it the
// forward selects stay FWD_RF and load_use_stall also covers every RAW hazard
// against the instructions currently in E and M.
// -----------------------------------------------------------------------------
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  ex_if
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
  } ex_reg_t;

  ex_reg_t e_q;
  ex_reg_t e_d;

  logic [1:0]      fu_fwd_a;
  logic [1:0]      fu_fwd_b;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] write_data;
  logic            load_hit;
  logic            raw_e_hit;
  logic            raw_m_hit;

  // ---------------------------------------------------------------------------
  // E register
  // ---------------------------------------------------------------------------
  always_comb begin
    e_d             = '0;
    e_d.rd1         = ex_if.rd1_d;
    e_d.rd2         = ex_if.rd2_d;
    e_d.imm_ext     = ex_if.imm_ext_d;
    e_d.pc          = ex_if.pc_d;
    e_d.pc_plus4    = ex_if.pc_plus4_d;
    e_d.rs1         = ex_if.rs1_d;
    e_d.rs2         = ex_if.rs2_d;
    e_d.rd          = ex_if.rd_d;
    e_d.alu_control = ex_if.alu_control_d;
    e_d.alu_src     = ex_if.alu_src_d;
    e_d.reg_write   = ex_if.reg_write_d;
    e_d.mem_write   = ex_if.mem_write_d;
    e_d.branch      = ex_if.branch_d;
    e_d.jump        = ex_if.jump_d;
    e_d.result_src  = ex_if.result_src_d;
  end

  // A flush arriving while stalled discards the held instruction.
  always_ff @(posedge clk) begin
    if (rst || ex_if.flush_e) begin
      e_q <= '0;
    end else if (!ex_if.stall_e) begin
      e_q <= e_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  forwarding_unit #(
    .RA_W (RA_W)
  ) u_fwd (
    .rs1_e_i       (e_q.rs1),
    .rs2_e_i       (e_q.rs2),
    .rd_m_i        (ex_if.rd_m),
    .reg_write_m_i (ex_if.reg_write_m),
    .rd_w_i        (ex_if.rd_w),
    .reg_write_w_i (ex_if.reg_write_w),
    .forward_a_e_o (fu_fwd_a),
    .forward_b_e_o (fu_fwd_b)
  );

  assign fwd_a = FWD_EN ? fu_fwd_a : FWD_RF;
  assign fwd_b = FWD_EN ? fu_fwd_b : FWD_RF;

  always_comb begin
    src_a = e_q.rd1;
    case (fwd_a)
      FWD_M:   src_a = ex_if.alu_result_m;
      FWD_W:   src_a = ex_if.result_w;
      default: src_a = e_q.rd1;
    endcase
  end

  always_comb begin
    write_data = e_q.rd2;
    case (fwd_b)
      FWD_M:   write_data = ex_if.alu_result_m;
      FWD_W:   write_data = ex_if.result_w;
      default: write_data = e_q.rd2;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall request to fetch/decode
  // ---------------------------------------------------------------------------
  assign load_hit  = (e_q.result_src == RES_LOAD) && (e_q.rd != '0) &&
                     ((e_q.rd == ex_if.rs1_d) || (e_q.rd == ex_if.rs2_d));
  assign raw_e_hit = e_q.reg_write && (e_q.rd != '0) &&
                     ((e_q.rd == ex_if.rs1_d) || (e_q.rd == ex_if.rs2_d));
  assign raw_m_hit = ex_if.reg_write_m && (ex_if.rd_m != '0) &&
                     ((ex_if.rd_m == ex_if.rs1_d) || (ex_if.rd_m == ex_if.rs2_d));

  // Gated by rst so M-stage feedback cannot raise a request while the core
  // is still in reset.
  assign ex_if.load_use_stall = !rst &&
                                (load_hit || (!FWD_EN && (raw_e_hit || raw_m_hit)));

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ex_if.src_a_e       = src_a;
  assign ex_if.write_data_e  = write_data;
  assign ex_if.src_b_e       = e_q.alu_src ? e_q.imm_ext : write_data;
  assign ex_if.alu_control_e = e_q.alu_control;
  assign ex_if.pc_e          = e_q.pc;
  assign ex_if.imm_ext_e     = e_q.imm_ext;
  assign ex_if.pc_plus4_e    = e_q.pc_plus4;
  assign ex_if.rd_e          = e_q.rd;
  assign ex_if.rs1_e         = e_q.rs1;
  assign ex_if.rs2_e         = e_q.rs2;
  assign ex_if.reg_write_e   = e_q.reg_write;
  assign ex_if.mem_write_e   = e_q.mem_write;
  assign ex_if.branch_e      = e_q.branch;
  assign ex_if.jump_e        = e_q.jump;
  assign ex_if.result_src_e  = e_q.result_src;
  assign ex_if.forward_a_e   = fwd_a;
  assign ex_if.forward_b_e   = fwd_b;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the 5-stage RISC-V core, directly upstream of the ALU.
- Registers the decode-stage operands and control signals, then resolves data hazards in execute. Hazards are resolved by forwarding from the memory (M) and writeback (W) stages.
- Drives the ALU inputs A, B and ALUControl, the store-data path, and the load-use stall request back to fetch/decode.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_e  in  1  hold the E register contents.
- flush_e  in  1  load a bubble into the E register.
- rd1_d, rd2_d  in  XLEN  register-file read data (rs1, rs2).
- imm_ext_d, pc_d, pc_plus4_d  in  XLEN  immediate, PC, PC+4.
- rs1_d, rs2_d, rd_d  in  RA_W  register addresses.
- alu_control_d  in  3  ALU operation code.
- alu_src_d  in  1  0 = B from rs2 path, 1 = B from immediate.
- reg_write_d, mem_write_d, branch_d, jump_d  in  1 each  control bits.
- result_src_d  in  2  00 = ALU, 01 = load, 10 = PC+4.
- rd_m  in  RA_W  M-stage destination register.
- reg_write_m  in  1  M-stage register-write enable.
- alu_result_m  in  XLEN  M-stage ALU result.
- rd_w  in  RA_W  W-stage destination register.
- reg_write_w  in  1  W-stage register-write enable.
- result_w  in  XLEN  W-stage writeback value.
- src_a_e  out  XLEN  ALU input A.
- src_b_e  out  XLEN  ALU input B.
- alu_control_e  out  3  registered ALU operation code.
- write_data_e  out  XLEN  forwarded rs2 value, used as store data.
- pc_e, imm_ext_e, pc_plus4_e  out  XLEN  registered copies.
- rd_e  out  RA_W  registered destination register.
- reg_write_e, mem_write_e, branch_e, jump_e  out  1 each  registered control bits.
- result_src_e  out  2  registered result-source select.
- forward_a_e, forward_b_e  out  2  forward selects: 00 = register file, 01 = W, 10 = M.
- load_use_stall  out  1  stall request to fetch/decode.

Behaviour:
- E register (one-cycle latency) holds every *_d input.
- Register update priority per rising edge:
  - rst: all fields are cleared to 0, which is a bubble (all control bits 0, addresses 0, data 0).
  - flush_e: all fields are cleared to 0, identical to reset. flush_e overrides stall_e when both are asserted.
  - stall_e: all fields hold their current values.
  - otherwise: all fields load from the *_d inputs.
- Forwarding is combinational on the registered rs1_e/rs2_e (internal):
  - forward_a_e = 10 if reg_write_m and rd_m == rs1_e and rs1_e != 0.
  - else 01 if reg_write_w and rd_w == rs1_e and rs1_e != 0.
  - else 00.
  - M has priority over W. forward_b_e follows the same rules using rs2_e.
- Operand selection:
  - src_a_e = mux(forward_a_e) of rd1_e / result_w / alu_result_m.
  - write_data_e = mux(forward_b_e) of rd2_e / result_w / alu_result_m.
  - src_b_e = imm_ext_e if alu_src_e is 1, else write_data_e.
- Register x0 is never forwarded, even when reg_write is set with rd = 0.
- load_use_stall = (result_src_e == 01) and rd_e != 0 and (rd_e == rs1_d or rd_e == rs2_d). It is combinational and is 0 during and immediately after reset.
- Reset or flush during a stall leaves a bubble; the held instruction is discarded.

Optional Feature:
- Macro EX_FORWARD_EN.
- Defined: forwarding behaves exactly as described in Behaviour.
- Undefined:
  - forward_a_e and forward_b_e are tied to 00; there is no forwarding.
  - load_use_stall additionally asserts on any RAW hazard with E or M: reg_write_e with rd_e matching rs1_d/rs2_d, or reg_write_m with rd_m matching rs1_d/rs2_d, rd != 0 in both cases.

Decomposition:
- Shared package core_pkg holds:
  - forward-select constants FWD_RF = 00, FWD_W = 01, FWD_M = 10;
  - result-source constants RES_ALU = 00, RES_LOAD = 01, RES_PC4 = 10;
  - XLEN.
- Sub-module forwarding_unit: purely combinational, produces forward_a_e and forward_b_e.

Test Plan:
- Reset: assert rst for 2 cycles with all *_d inputs nonzero -> every output 0 and load_use_stall = 0.
- Forwarding from M: rd1_d = 5, rs1_d = 3 registered; then rd_m = 3, reg_write_m = 1, alu_result_m = 0x00000040 -> forward_a_e = 10, src_a_e = 0x00000040.
- M over W priority with x0 exclusion:
  - rd_m = rd_w = 7, both write enables set, alu_result_m = 0x11, result_w = 0x22, rs2_e = 7, alu_src_e = 0 -> src_b_e = 0x11.
  - Same hazard with rs2_e = 0 -> forward_b_e = 00 and src_b_e = rd2_e.
- Load-use: E holds result_src_e = 01, rd_e = 9; decode presents rs2_d = 9 -> load_use_stall = 1. The next cycle with flush_e = 1 -> reg_write_e = 0 and mem_write_e = 0.
- Stall/flush priority:
  - stall_e = 1 for 3 cycles while the *_d inputs change -> outputs unchanged.
  - stall_e = 1 and flush_e = 1 together -> bubble loaded.
- Immediate path: alu_src_d = 1, imm_ext_d = 0xFFFFFFF0, with a forwarding hit active on rs2 -> src_b_e = 0xFFFFFFF0 and write_data_e = the forwarded value.
